// File: rtl/sap_pkg.sv
// Shared opcodes and rotate FSM state for the SAP register bank.
// Pure declarations: no latency, no flow control.
package sap_pkg;
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_INC  = 3'b010;
   localparam logic [2:0] OP_DEC  = 3'b011;
   localparam logic [2:0] OP_CLR  = 3'b100;
   localparam logic [2:0] OP_ROTL = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_SHR  = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ROT  = 1'b1
   } state_t;
endpackage

// File: rtl/sap_reg_op_unit.sv
// Combinational register op: (op, value, din) -> result, carry, zero; ROTL is a 1-bit step.
// Latency 0; no flow control.
module sap_reg_op_unit
   import sap_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] value,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero_out
);
   always_comb begin
      result    = value;
      carry_out = 1'b0;
      case (op)
         OP_LOAD: result = din;
         OP_INC:  {carry_out, result} = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
         // Borrow from 0 leaves the extra top bit set.
         OP_DEC:  {carry_out, result} = {1'b0, value} - {{WIDTH{1'b0}}, 1'b1};
         OP_CLR:  result = '0;
         OP_ROTL: begin
            result    = {value[WIDTH-2:0], value[WIDTH-1]};
            carry_out = value[WIDTH-1];
         end
         OP_SHL: begin
            result    = {value[WIDTH-2:0], 1'b0};
            carry_out = value[WIDTH-1];
         end
         OP_SHR: begin
            result    = {1'b0, value[WIDTH-1:1]};
            carry_out = value[0];
         end
         default: ;
      endcase
      zero_out = (result == '0);
   end
endmodule

// File: rtl/sap_reg_bank.sv
// Register bank with in-place ops, two combinational read ports and registered zero/carry.
// Single-cycle ops land at the accepting edge; ROTL by k holds busy for k cycles and ignores nL meanwhile.
module sap_reg_bank
   import sap_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 4,
   parameter int SEL_W    = $clog2(NUM_REGS),
   parameter int ROT_W    = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             nCLR,
   input  logic             nL,
   input  logic [2:0]       op,
   input  logic [SEL_W-1:0] wsel,
   input  logic [WIDTH-1:0] bin,
   input  logic [SEL_W-1:0] rsel_a,
   input  logic [SEL_W-1:0] rsel_b,
   output logic [WIDTH-1:0] aout,
   output logic [WIDTH-1:0] bout,
   output logic             zero,
   output logic             carry,
   output logic             busy
);
   localparam logic [SEL_W:0] NREG_LIM = (SEL_W+1)'(NUM_REGS);

   logic [WIDTH-1:0] regs [NUM_REGS];
   state_t           state;
   logic [ROT_W-1:0] rot_cnt;
   logic [SEL_W-1:0] rot_sel;

   logic [WIDTH-1:0] wr_cur, rot_cur, unit_val, unit_res;
   logic [2:0]       unit_op;
   logic             unit_carry, unit_zero;
   logic             rotating, wsel_ok, accept, wr_en;
   logic [SEL_W-1:0] wr_sel;
   logic [ROT_W-1:0] rot_amt;

   // Out-of-range selects match no entry and therefore read as zero.
   always_comb begin
      aout    = '0;
      bout    = '0;
      wr_cur  = '0;
      rot_cur = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rsel_a  == SEL_W'(i)) aout    = regs[i];
         if (rsel_b  == SEL_W'(i)) bout    = regs[i];
         if (wsel    == SEL_W'(i)) wr_cur  = regs[i];
         if (rot_sel == SEL_W'(i)) rot_cur = regs[i];
      end
   end

   assign rotating = (state == ST_ROT);
   assign busy     = rotating;
   assign wsel_ok  = ({1'b0, wsel} < NREG_LIM);
   assign accept   = !nL && !rotating && wsel_ok;
   assign rot_amt  = bin[ROT_W-1:0];
   assign unit_op  = rotating ? OP_ROTL : op;
   assign unit_val = rotating ? rot_cur : wr_cur;
   assign wr_sel   = rotating ? rot_sel : wsel;
   assign wr_en    = rotating || (accept && op != OP_NOP && op != OP_ROTL);

   sap_reg_op_unit #(.WIDTH(WIDTH)) u_op (
      .op        (unit_op),
      .value     (unit_val),
      .din       (bin),
      .result    (unit_res),
      .carry_out (unit_carry),
      .zero_out  (unit_zero)
   );

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (wr_sel == SEL_W'(i)) regs[i] <= unit_res;
      end
   end

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         state   <= ST_IDLE;
         rot_cnt <= '0;
         rot_sel <= '0;
         zero    <= 1'b0;
         carry   <= 1'b0;
      end else if (rotating) begin
         rot_cnt <= rot_cnt - ROT_W'(1);
         if (rot_cnt == ROT_W'(1)) begin
            state <= ST_IDLE;
            carry <= unit_carry;
            zero  <= unit_zero;
         end
      end else if (accept) begin
         case (op)
            OP_NOP: ;
            OP_ROTL: begin
               if (rot_amt == '0) begin
                  zero <= (wr_cur == '0);
               end else begin
                  state   <= ST_ROT;
                  rot_cnt <= rot_amt;
                  rot_sel <= wsel;
               end
            end
            default: begin
               carry <= unit_carry;
               zero  <= unit_zero;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sap_reg_bank.sv
// Bench for sap_reg_bank: directed vector table, reset/rotate corners, random ops against a model.
module tb_sap_reg_bank;
   logic       CLK = 1'b0;
   logic       nCLR;
   logic       nL;
   logic [2:0] op;
   logic [1:0] wsel, rsel_a, rsel_b;
   logic [7:0] bin, aout, bout;
   logic       zero, carry, busy;

   logic       l3;
   logic [2:0] op3;
   logic [1:0] ws3, ra3, rb3;
   logic [7:0] bin3, a3, b3;
   logic       z3, c3, busy3;

   int checks = 0;
   int failures = 0;

   int m_reg [4];
   int m_zero, m_carry, m_rem, m_sel;

   always #5 CLK = ~CLK;

   sap_reg_bank dut (
      .CLK(CLK), .nCLR(nCLR), .nL(nL), .op(op), .wsel(wsel), .bin(bin),
      .rsel_a(rsel_a), .rsel_b(rsel_b), .aout(aout), .bout(bout),
      .zero(zero), .carry(carry), .busy(busy)
   );

   sap_reg_bank #(.NUM_REGS(3)) dut3 (
      .CLK(CLK), .nCLR(nCLR), .nL(l3), .op(op3), .wsel(ws3), .bin(bin3),
      .rsel_a(ra3), .rsel_b(rb3), .aout(a3), .bout(b3),
      .zero(z3), .carry(c3), .busy(busy3)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
      m_zero = 0; m_carry = 0; m_rem = 0; m_sel = 0;
   endtask

   // Next state of the bank for one clock edge, from the op definitions.
   task automatic model_step(input logic l, input int o, input int s, input int b);
      int v, c, k;
      if (m_rem > 0) begin
         v = ((m_reg[m_sel] * 2) + (m_reg[m_sel] / 128)) % 256;
         m_reg[m_sel] = v;
         m_rem--;
         if (m_rem == 0) begin
            m_carry = v % 2;
            m_zero  = (v == 0);
         end
      end else if (!l) begin
         v = m_reg[s];
         c = 0;
         case (o)
            1: v = b;
            2: begin c = (v == 255); v = (v + 1) % 256; end
            3: begin c = (v == 0); v = (v + 255) % 256; end
            4: v = 0;
            6: begin c = v / 128; v = (v * 2) % 256; end
            7: begin c = v % 2; v = v / 2; end
            default: ;
         endcase
         if (o == 5) begin
            k = b % 8;
            if (k == 0) m_zero = (v == 0);
            else begin m_rem = k; m_sel = s; end
         end else if (o != 0) begin
            m_reg[s] = v;
            m_carry  = c;
            m_zero   = (v == 0);
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         rsel_a = 2'(i);
         rsel_b = 2'((i + 1) % 4);
         #1;
         chk("aout", int'(aout), m_reg[i]);
         chk("bout", int'(bout), m_reg[(i + 1) % 4]);
      end
      chk("zero", int'(zero), m_zero);
      chk("carry", int'(carry), m_carry);
      chk("busy", int'(busy), int'(m_rem > 0));
   endtask

   task automatic cycle(input logic l, input logic [2:0] o, input logic [1:0] s, input logic [7:0] b);
      nL = l; op = o; wsel = s; bin = b; rsel_a = s;
      #1;
      chk("read_before_edge", int'(aout), m_reg[s]);
      model_step(l, int'(o), int'(s), int'(b));
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic cycle3(input logic l, input logic [2:0] o, input logic [1:0] s, input logic [7:0] b);
      l3 = l; op3 = o; ws3 = s; bin3 = b;
      @(posedge CLK);
      #1;
      l3 = 1'b1;
   endtask

   typedef struct {
      logic       nl;
      logic [2:0] op;
      logic [1:0] ws;
      logic [7:0] b;
      logic [7:0] exp_r;
      logic       exp_z;
      logic       exp_c;
      logic       exp_busy;
   } vec_t;

   vec_t vt [22];

   initial begin
      vt[0]  = '{1'b0, 3'd1, 2'd1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{1'b0, 3'd1, 2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{1'b0, 3'd2, 2'd2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 3'd3, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
      vt[4]  = '{1'b1, 3'd2, 2'd2, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 3'd1, 2'd0, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 3'd6, 2'd0, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0};
      vt[7]  = '{1'b0, 3'd7, 2'd0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{1'b0, 3'd1, 2'd3, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 3'd5, 2'd3, 8'h03, 8'h81, 1'b0, 1'b0, 1'b1};
      vt[10] = '{1'b0, 3'd1, 2'd3, 8'h55, 8'h03, 1'b0, 1'b0, 1'b1};
      vt[11] = '{1'b1, 3'd0, 2'd3, 8'h00, 8'h06, 1'b0, 1'b0, 1'b1};
      vt[12] = '{1'b1, 3'd0, 2'd3, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0};
      vt[13] = '{1'b0, 3'd1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vt[14] = '{1'b0, 3'd3, 2'd1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
      vt[15] = '{1'b0, 3'd5, 2'd1, 8'h08, 8'hFF, 1'b0, 1'b1, 1'b0};
      vt[16] = '{1'b0, 3'd4, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vt[17] = '{1'b0, 3'd0, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vt[18] = '{1'b0, 3'd1, 2'd0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0};
      vt[19] = '{1'b0, 3'd5, 2'd0, 8'h02, 8'h40, 1'b0, 1'b0, 1'b1};
      vt[20] = '{1'b1, 3'd0, 2'd0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1};
      vt[21] = '{1'b1, 3'd0, 2'd0, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0};

      nCLR = 1'b0; nL = 1'b1; op = 3'd0; wsel = 2'd0; bin = 8'h00;
      rsel_a = 2'd0; rsel_b = 2'd0;
      l3 = 1'b1; op3 = 3'd0; ws3 = 2'd0; bin3 = 8'h00; ra3 = 2'd0; rb3 = 2'd0;
      model_reset();
      #2;
      check_all();
      @(negedge CLK);
      nCLR = 1'b1;

      for (int i = 0; i < 22; i++) begin
         cycle(vt[i].nl, vt[i].op, vt[i].ws, vt[i].b);
         rsel_a = vt[i].ws;
         #1;
         chk($sformatf("vec%0d_reg", i), int'(aout), int'(vt[i].exp_r));
         chk($sformatf("vec%0d_zero", i), int'(zero), int'(vt[i].exp_z));
         chk($sformatf("vec%0d_carry", i), int'(carry), int'(vt[i].exp_c));
         chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].exp_busy));
      end

      // Reset in the middle of a rotate aborts it at once.
      cycle(1'b0, 3'd1, 2'd2, 8'h81);
      cycle(1'b0, 3'd5, 2'd2, 8'h05);
      cycle(1'b1, 3'd0, 2'd2, 8'h00);
      chk("busy_mid_rot", int'(busy), 1);
      nCLR = 1'b0;
      model_reset();
      #1;
      chk("busy_async_clear", int'(busy), 0);
      check_all();
      @(negedge CLK);
      nCLR = 1'b1;
      cycle(1'b0, 3'd1, 2'd0, 8'h2A);
      rsel_a = 2'd0;
      #1;
      chk("load_after_reset", int'(aout), 8'h2A);
      chk("busy_after_reset", int'(busy), 0);

      for (int n = 0; n < 400; n++) begin
         cycle(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end

      // Three-register build: out-of-range target and select.
      cycle3(1'b0, 3'd1, 2'd1, 8'hAA);
      cycle3(1'b0, 3'd1, 2'd2, 8'hFF);
      cycle3(1'b0, 3'd2, 2'd2, 8'h00);
      chk("r3_inc_zero", int'(z3), 1);
      chk("r3_inc_carry", int'(c3), 1);
      cycle3(1'b0, 3'd1, 2'd3, 8'h55);
      chk("r3_bad_wsel_zero", int'(z3), 1);
      chk("r3_bad_wsel_carry", int'(c3), 1);
      ra3 = 2'd1; rb3 = 2'd2;
      #1;
      chk("r3_reg1", int'(a3), 8'hAA);
      chk("r3_reg2", int'(b3), 8'h00);
      ra3 = 2'd3; rb3 = 2'd0;
      #1;
      chk("r3_rsel_oob", int'(a3), 0);
      chk("r3_reg0", int'(b3), 0);
      cycle3(1'b0, 3'd5, 2'd3, 8'h02);
      chk("r3_bad_rotl_busy", int'(busy3), 0);
      ra3 = 2'd1;
      #1;
      chk("r3_reg1_kept", int'(a3), 8'hAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sap_reg_bank.md
Name: sap_reg_bank

Overview:
Parametrised successor to the single SAP-1 B register: a bank of NUM_REGS general registers, each WIDTH bits, written from the W bus under an active-low load strobe. Besides plain load, the bank executes in-place register ops: clear, increment, decrement, shift, and a multi-cycle rotate. Two combinational read ports feed the adder/subtractor and the output path. Registered zero and carry flags go to the controller-sequencer for SAP-2-style conditional jumps.

Parameters:
WIDTH, 8, register and bus width in bits (>=2)
NUM_REGS, 4, number of registers (>=2; need not be a power of 2)
SEL_W, $clog2(NUM_REGS), register select width (derived; do not override)
ROT_W, $clog2(WIDTH), rotate-amount width (derived)

Ports:
CLK  in  1  system clock, rising-edge
nCLR  in  1  asynchronous active-low reset
nL  in  1  active-low op strobe; op accepted on a rising CLK edge when nL=0 and busy=0
op  in  3  opcode: 000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 CLR, 101 ROTL, 110 SHL, 111 SHR
wsel  in  SEL_W  target register for op
bin  in  WIDTH  W-bus data; LOAD value; ROTL amount in bin[ROT_W-1:0]
rsel_a  in  SEL_W  read port A select
rsel_b  in  SEL_W  read port B select
aout  out  WIDTH  register[rsel_a], combinational
bout  out  WIDTH  register[rsel_b], combinational (to adder/subtractor)
zero  out  1  registered: last completed result == 0
carry  out  1  registered carry/borrow/shifted-out bit
busy  out  1  high while ROTL is in progress

Behaviour:
- Reset (nCLR=0, async): all registers 0, zero=0, carry=0, busy=0, FSM=IDLE. Takes effect immediately and overrides a rotate in progress (the rotate is aborted).
- Reads: combinational, no latency. A same-cycle write to the selected register shows the old value until the edge. rsel >= NUM_REGS reads all zeros.
- Accept: on a rising edge with nL=0 and busy=0. nL=0 while busy=1 is ignored; no queuing.
- wsel >= NUM_REGS: op is discarded. No register, flag or busy change.
- Single-cycle ops update the register and flags at the accepting edge:
  - NOP: no change; flags hold.
  - LOAD: reg=bin; carry=0.
  - CLR: reg=0; carry=0.
  - INC: reg=reg+1 mod 2^WIDTH; carry=1 only on wrap from all-ones to 0.
  - DEC: reg=reg-1 mod 2^WIDTH; carry=1 only on borrow from 0 to all-ones.
  - SHL: carry=old MSB; LSB filled with 0.
  - SHR: carry=old LSB; MSB filled with 0.
  - For every op except NOP, zero is set from the new register value.
- ROTL, amount k = bin[ROT_W-1:0], latched with wsel at accept:
  - k=0: behaves as a single-cycle op. Register unchanged; zero set from the register; carry holds; busy stays 0.
  - k>0: FSM goes IDLE->ROT at the accepting edge, and busy=1 from the following cycle.
  - Each edge in ROT rotates the latched register left by 1 and decrements the remaining count.
  - The register reaches its final value k edges after accept. busy drops in the same edge, so busy is high for exactly k cycles.
  - carry and zero update only at the final rotate. carry = final LSB, the last bit rotated out of the MSB.
  - Intermediate values are visible on the read ports.
- FSM states: IDLE, ROT. ROT->IDLE when the remaining count reaches 0. There are no other states.

Decomposition:
- Shared package sap_pkg: opcode localparams (OP_NOP..OP_SHR) and the FSM state enum.
- Sub-module sap_reg_op_unit: purely combinational (op, value) -> (result, carry_out, zero_out). It is reused for single-cycle ops and per-step rotate, and is unit-testable.
- sap_reg_bank holds the storage array, accept logic, rotate FSM/counter, flags and read muxes.

Test Plan:
- Reset then LOAD 8'h05 into reg1 (op=001, nL=0, one edge) -> reg1=8'h05, bout(rsel_b=1)=8'h05, zero=0, carry=0; other regs=0.
- INC reg2 from 8'hFF -> reg2=8'h00, carry=1, zero=1. Then DEC reg2 -> 8'hFF, carry=1, zero=0. nL=1 on the next edge -> no change.
- SHL reg0=8'h81 -> 8'h02, carry=1. Then SHR -> 8'h01, carry=0.
- ROTL reg3=8'h81 with bin=8'h03 -> busy high 3 cycles; reg3 steps 8'h03, 8'h06, 8'h0C; then busy=0, carry=0. An LOAD strobe issued during busy is ignored.
- nCLR pulsed low mid-rotate -> all regs 0, busy=0 immediately; LOAD 8'h2A on the next edge is accepted.
- NUM_REGS=3 build: LOAD with wsel=3 -> no register or flag change; aout with rsel_a=3 reads 0.
